// File: rtl/max1379_adc_emulator.sv
// max1379_adc_emulator
//   Stand-in for the MAX1379 dual-channel serial ADC. It watches the controller's
//   CNVST/SCLK/CS_N, latches two DATA_W-bit samples when a conversion starts, and
//   shifts them out MSB first on ADC_OUT[1:0]. The controller samples on the rising
//   edge of SCLK, so new bits are driven after each SCLK fall.
//
//   Ports
//     CLOCK_50MHz   system clock, all logic on its rising edge
//     RESET         synchronous, active-high reset
//     ADC_SCLK      serial clock from the controller (<= CLOCK_50MHz/8)
//     ADC_CNVST     conversion start, active low; falling edge starts a frame
//     ADC_CS_N      chip select, active low; high aborts and silences the link
//     CH0_DATA      sample for channel 0 (ADC_OUT[0])
//     CH1_DATA      sample for channel 1 (ADC_OUT[1])
//     ADC_OUT       serial data, [0]=CH0, [1]=CH1
//     ACTIVE        high from conversion start until frame done or abort
//     SAMPLE_TAKEN  1-cycle pulse when CH0/CH1_DATA are latched
//     FRAME_DONE    1-cycle pulse once the LSB has been clocked out
module max1379_adc_emulator #(
  parameter int DATA_W      = 12,
  parameter int LATENCY     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50MHz,
  input  logic              RESET,
  input  logic              ADC_SCLK,
  input  logic              ADC_CNVST,
  input  logic              ADC_CS_N,
  input  logic [DATA_W-1:0] CH0_DATA,
  input  logic [DATA_W-1:0] CH1_DATA,
  output logic [1:0]        ADC_OUT,
  output logic              ACTIVE,
  output logic              SAMPLE_TAKEN,
  output logic              FRAME_DONE
);

  localparam int NUM_LANES = 2;
  localparam int EW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [EW-1:0] LAT_CNT  = EW'(LATENCY);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  // Link synchronizer: bit 0 = SCLK, 1 = CNVST, 2 = CS_N.
  // Left free-running through RESET so that deasserting reset never fabricates
  // an edge from stale history; only the frame state is cleared.
  logic [SYNC_STAGES-1:0][2:0] sync_pipe;
  logic [2:0]                  sync_prev;
  logic [2:0]                  sync_s;

  always_ff @(posedge CLOCK_50MHz) begin
    sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {ADC_CS_N, ADC_CNVST, ADC_SCLK}};
    sync_prev <= sync_pipe[SYNC_STAGES-1];
  end

  assign sync_s = sync_pipe[SYNC_STAGES-1];

  logic sclk_rise, sclk_fall, cnvst_fall, cnvst_rise, cs_n_s;
  assign sclk_rise  =  sync_s[0] & ~sync_prev[0];
  assign sclk_fall  = ~sync_s[0] &  sync_prev[0];
  assign cnvst_rise =  sync_s[1] & ~sync_prev[1];
  assign cnvst_fall = ~sync_s[1] &  sync_prev[1];
  assign cs_n_s     =  sync_s[2];

  state_t                             state;
  logic [NUM_LANES-1:0][DATA_W-1:0]   sh;
  logic [EW-1:0]                      edge_cnt;
  logic [BW-1:0]                      bit_cnt;
  logic [NUM_LANES-1:0]               sh_msb;
  logic                               abort;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) sh_msb[i] = sh[i][DATA_W-1];
  end

  // CS_N high kills any frame; a CNVST rise only aborts while bits are pending.
  // Abort outranks any SCLK edge seen in the same cycle.
  assign abort = (cs_n_s && state != S_IDLE) ||
                 (cnvst_rise && (state == S_WAIT || state == S_SHIFT));

  always_ff @(posedge CLOCK_50MHz) begin
    SAMPLE_TAKEN <= 1'b0;
    FRAME_DONE   <= 1'b0;
    if (RESET) begin
      state    <= S_IDLE;
      ADC_OUT  <= '0;
      ACTIVE   <= 1'b0;
      sh       <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      ADC_OUT <= '0;
      ACTIVE  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ADC_OUT <= '0;
          if (cnvst_fall && !cs_n_s) begin
            sh[0]        <= CH0_DATA;
            sh[1]        <= CH1_DATA;
            SAMPLE_TAKEN <= 1'b1;
            ACTIVE       <= 1'b1;
            edge_cnt     <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sclk_rise && edge_cnt < LAT_CNT) edge_cnt <= edge_cnt + 1'b1;
          // Drive the MSB and pre-shift so the next fall finds the next bit at the top.
          if (sclk_fall && edge_cnt == LAT_CNT) begin
            ADC_OUT <= sh_msb;
            for (int i = 0; i < NUM_LANES; i++) sh[i] <= sh[i] << 1;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt == BIT_LAST) begin
              // The rise that consumes the LSB ends the frame.
              bit_cnt    <= BIT_END;
              ADC_OUT    <= '0;
              FRAME_DONE <= 1'b1;
              ACTIVE     <= 1'b0;
              state      <= S_DONE;
            end else if (bit_cnt < BIT_END) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && bit_cnt < BIT_END) begin
            ADC_OUT <= sh_msb;
            for (int i = 0; i < NUM_LANES; i++) sh[i] <= sh[i] << 1;
          end
        end
        S_DONE: begin
          ADC_OUT <= '0;
          if (cnvst_rise) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          ADC_OUT <= '0;
          ACTIVE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max1379_adc_emulator.sv
// Directed bench for max1379_adc_emulator: drives controller-style frames
// (SCLK = clock/8, CNVST dropped with rise E0, bits captured at E4..E15).
module tb_max1379_adc_emulator;

  logic        CLOCK_50MHz = 1'b0;
  logic        RESET, ADC_SCLK, ADC_CNVST, ADC_CS_N;
  logic [11:0] CH0_DATA, CH1_DATA;
  logic [1:0]  ADC_OUT;
  logic        ACTIVE, SAMPLE_TAKEN, FRAME_DONE;

  always #10 CLOCK_50MHz = ~CLOCK_50MHz;

  max1379_adc_emulator #(.DATA_W(12), .LATENCY(3), .SYNC_STAGES(2)) dut (
    .CLOCK_50MHz (CLOCK_50MHz),
    .RESET       (RESET),
    .ADC_SCLK    (ADC_SCLK),
    .ADC_CNVST   (ADC_CNVST),
    .ADC_CS_N    (ADC_CS_N),
    .CH0_DATA    (CH0_DATA),
    .CH1_DATA    (CH1_DATA),
    .ADC_OUT     (ADC_OUT),
    .ACTIVE      (ACTIVE),
    .SAMPLE_TAKEN(SAMPLE_TAKEN),
    .FRAME_DONE  (FRAME_DONE)
  );

  int   errors = 0, checks = 0;
  int   done_cnt = 0, smp_cnt = 0;
  logic out_seen = 1'b0;

  always @(negedge CLOCK_50MHz) begin
    if (FRAME_DONE)     done_cnt++;
    if (SAMPLE_TAKEN)   smp_cnt++;
    if (ADC_OUT != 2'b00) out_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50MHz);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs SCLK rises E0..E(stop_e-1); captures bits sampled at E4.. just before each rise.
  task automatic frame(input logic [11:0] c0, input logic [11:0] c1, input int stop_e,
                       input int chg_e, input logic [11:0] chg_v,
                       output logic [11:0] cap0, output logic [11:0] cap1, output logic act_mid);
    CH0_DATA = c0; CH1_DATA = c1;
    cap0 = '0; cap1 = '0; act_mid = 1'b0;
    ADC_CNVST = 1'b0; ADC_SCLK = 1'b1; tick(4);
    ADC_SCLK = 1'b0; tick(4);
    for (int e = 1; e < stop_e; e++) begin
      if (e == chg_e) CH0_DATA = chg_v;
      if (e == 2) act_mid = ACTIVE;
      if (e >= 4) begin
        cap0[15-e] = ADC_OUT[0];
        cap1[15-e] = ADC_OUT[1];
      end
      ADC_SCLK = 1'b1; tick(4);
      ADC_SCLK = 1'b0; tick(4);
    end
  endtask

  task automatic end_frame();
    ADC_CNVST = 1'b1;
    tick(8);
  endtask

  typedef struct {
    logic [11:0] c0, c1;
    logic [11:0] e0, e1;
  } vec_t;

  initial begin
    vec_t        v [5];
    logic [11:0] cap0, cap1;
    logic        am;
    int          d0, s0;

    v[0] = '{12'hA5C, 12'h3F1, 12'hA5C, 12'h3F1};
    v[1] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    v[2] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
    v[3] = '{12'h555, 12'hAAA, 12'h555, 12'hAAA};
    v[4] = '{12'h001, 12'h800, 12'h001, 12'h800};

    RESET = 1'b1; ADC_SCLK = 1'b0; ADC_CNVST = 1'b1; ADC_CS_N = 1'b0;
    CH0_DATA = '0; CH1_DATA = '0;
    tick(5);
    chk("rst_out",    ADC_OUT, 2'b00);
    chk("rst_active", ACTIVE, 0);
    chk("rst_sample", SAMPLE_TAKEN, 0);
    chk("rst_done",   FRAME_DONE, 0);
    RESET = 1'b0;
    tick(4);

    // Table frames, back to back with CNVST high one SCLK period between.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt; s0 = smp_cnt;
      frame(v[i].c0, v[i].c1, 16, 0, 12'h0, cap0, cap1, am);
      chk($sformatf("vec%0d_ch0", i), cap0, v[i].e0);
      chk($sformatf("vec%0d_ch1", i), cap1, v[i].e1);
      chk($sformatf("vec%0d_active_mid", i), am, 1);
      chk($sformatf("vec%0d_done_cnt", i), done_cnt - d0, 1);
      chk($sformatf("vec%0d_smp_cnt", i), smp_cnt - s0, 1);
      end_frame();
      chk($sformatf("vec%0d_active_gap", i), ACTIVE, 0);
      chk($sformatf("vec%0d_out_gap", i), ADC_OUT, 0);
    end

    // Input change three SCLK periods into SHIFT must not disturb the frame.
    frame(12'h123, 12'h0AB, 16, 7, 12'h456, cap0, cap1, am);
    chk("chg_ch0", cap0, 12'h123);
    chk("chg_ch1", cap1, 12'h0AB);
    end_frame();
    frame(12'h456, 12'h0AB, 16, 0, 12'h0, cap0, cap1, am);
    chk("chg_next_ch0", cap0, 12'h456);
    end_frame();

    // CNVST raised after 5 bits.
    d0 = done_cnt;
    frame(12'hA5C, 12'h3F1, 9, 0, 12'h0, cap0, cap1, am);
    chk("abort_bits_ch0", cap0[11:7], 5'b10100);
    chk("abort_bits_ch1", cap1[11:7], 5'b00111);
    ADC_CNVST = 1'b1; tick(4);
    chk("abort_out",    ADC_OUT, 0);
    chk("abort_active", ACTIVE, 0);
    tick(8);
    chk("abort_no_done", done_cnt - d0, 0);
    frame(12'h3C3, 12'hC3C, 16, 0, 12'h0, cap0, cap1, am);
    chk("abort_next_ch0", cap0, 12'h3C3);
    chk("abort_next_ch1", cap1, 12'hC3C);
    end_frame();

    // CS_N high during the CNVST fall: nothing happens.
    ADC_CS_N = 1'b1; tick(4);
    s0 = smp_cnt; d0 = done_cnt; out_seen = 1'b0;
    frame(12'hFFF, 12'hFFF, 16, 0, 12'h0, cap0, cap1, am);
    end_frame();
    chk("csn_no_sample", smp_cnt - s0, 0);
    chk("csn_out_quiet", out_seen, 0);
    chk("csn_no_done",   done_cnt - d0, 0);
    ADC_CS_N = 1'b0; tick(8);

    // CS_N high mid-SHIFT aborts.
    d0 = done_cnt;
    frame(12'hFFF, 12'hFFF, 9, 0, 12'h0, cap0, cap1, am);
    ADC_CS_N = 1'b1; tick(4);
    chk("csn_abort_out",    ADC_OUT, 0);
    chk("csn_abort_active", ACTIVE, 0);
    ADC_CS_N = 1'b0; ADC_CNVST = 1'b1; tick(8);
    chk("csn_abort_no_done", done_cnt - d0, 0);

    // One-clock RESET pulse mid-SHIFT.
    frame(12'hFFF, 12'hFFF, 9, 0, 12'h0, cap0, cap1, am);
    RESET = 1'b1; tick(1);
    RESET = 1'b0;
    chk("mid_rst_out",    ADC_OUT, 0);
    chk("mid_rst_active", ACTIVE, 0);
    chk("mid_rst_sample", SAMPLE_TAKEN, 0);
    chk("mid_rst_done",   FRAME_DONE, 0);
    ADC_CNVST = 1'b1; tick(8);
    d0 = done_cnt;
    frame(12'h800, 12'h001, 16, 0, 12'h0, cap0, cap1, am);
    chk("post_rst_ch0", cap0, 12'h800);
    chk("post_rst_ch1", cap1, 12'h001);
    chk("post_rst_done", done_cnt - d0, 1);
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
